// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: request (in_*) and IMEM write (wr_*) handshake bundle; slave = encoder, master = loader
interface mips_instr_encoder_if #(
  parameter int AW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_op;
  logic [5:0]    in_funct;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  modport master (
    output in_valid, in_op, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );
  modport slave (
    input  in_valid, in_op, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: validates/packs MIPS150 requests into R/I/J words, queues them and writes IMEM at auto-incrementing addresses; ports: clk, rst_n (async low), restart, bus (slave), err, err_count, instr_count
module mips_instr_encoder #(
  parameter int            DEPTH     = 4,
  parameter int            AW        = 12,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  mips_instr_encoder_if.slave bus,
  output logic                err,
  output logic [7:0]          err_count,
  output logic [AW-1:0]       instr_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [5:0] op, fn;
  logic shift, jr, jalr, r_ok, i_ok, j_op, ok;
  logic [4:0] rs_r, rt_r, rd_r, sh_r, rs_i, rt_i;
  logic [31:0] word;
  logic rdy, enc_v, enc_bad;
  logic [31:0] enc_w;
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] mcnt, occ;
  logic out_v;
  logic [31:0] out_d;
  logic [AW-1:0] addr;
  logic acc, push, pop, load;
  assign op = bus.in_op;
  assign fn = bus.in_funct;
  always_comb begin
    shift = fn inside {6'h00, 6'h02, 6'h03};
    jr    = fn == 6'h08;
    jalr  = fn == 6'h09;
    r_ok  = shift | jr | jalr | (fn inside {6'h04, 6'h06, 6'h07, 6'h21, 6'h23, [6'h24:6'h27], 6'h2A, 6'h2B});
    j_op  = op inside {6'h02, 6'h03};
    i_ok  = op inside {6'h01, [6'h04:6'h07], [6'h09:6'h0F], 6'h20, 6'h21, [6'h23:6'h25], 6'h28, 6'h29, 6'h2B};
    ok    = (op == 6'h00) ? r_ok : (i_ok | j_op);
    rs_r  = shift ? 5'd0 : bus.in_rs;
    rt_r  = (jr | jalr) ? 5'd0 : bus.in_rt;
    rd_r  = jr ? 5'd0 : (jalr && bus.in_rd == 5'd0) ? 5'd31 : bus.in_rd;
    sh_r  = shift ? bus.in_shamt : 5'd0;
    rs_i  = (op == 6'h0F) ? 5'd0 : bus.in_rs;
    rt_i  = (op inside {6'h06, 6'h07}) ? 5'd0 : (op == 6'h01) ? {4'b0, fn[0]} : bus.in_rt;
    word  = (op == 6'h00) ? {6'b0, rs_r, rt_r, rd_r, sh_r, fn} :
            j_op ? {op, bus.in_target} : {op, rs_i, rt_i, bus.in_imm};
  end
  // occ counts the FIFO storage plus the output register; the encode register adds one more slot
  assign occ          = mcnt + (PW+1)'(out_v);
  assign bus.in_ready = rdy & ~restart & ~(enc_v & occ == FULL);
  assign acc          = bus.in_valid & bus.in_ready;
  assign pop          = out_v & bus.wr_ready;
  assign push         = enc_v & ((occ != FULL) | pop);
  assign load         = (mcnt != '0) & (~out_v | pop);
  assign bus.wr_valid = out_v;
  assign bus.wr_data  = out_d;
  assign bus.wr_addr  = addr;
  always_ff @(posedge clk)
    if (push) mem[wp] <= enc_w;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy         <= 1'b0;
      enc_v       <= 1'b0;
      enc_bad     <= 1'b0;
      enc_w       <= '0;
      wp          <= '0;
      rp          <= '0;
      mcnt        <= '0;
      out_v       <= 1'b0;
      out_d       <= '0;
      addr        <= BASE_ADDR;
      instr_count <= '0;
      err         <= 1'b0;
      err_count   <= '0;
    end else if (restart) begin
      rdy         <= 1'b1;
      enc_v       <= 1'b0;
      enc_bad     <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      mcnt        <= '0;
      out_v       <= 1'b0;
      out_d       <= '0;
      addr        <= BASE_ADDR;
      instr_count <= '0;
      err         <= 1'b0;
    end else begin
      rdy     <= 1'b1;
      enc_v   <= acc ? ok : enc_v & ~push;
      enc_bad <= acc & ~ok;
      if (acc) enc_w <= word;
      err <= enc_bad;
      if (enc_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (push) wp <= wp + 1'b1;
      if (load) begin
        out_d <= mem[rp];
        rp    <= rp + 1'b1;
      end
      out_v <= load | (out_v & ~pop);
      mcnt  <= mcnt + (PW+1)'(push) - (PW+1)'(load);
      if (pop) begin
        addr        <= addr + 1'b1;
        instr_count <= instr_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: table-driven encode vectors plus backpressure, restart and async-reset sequences
module tb_mips_instr_encoder;
  localparam int AW = 12;
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        bad;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  logic err;
  logic [7:0] err_count;
  logic [AW-1:0] instr_count;
  int checks = 0;
  int errors = 0;
  int exp_addr = 0;
  int exp_err = 0;
  vec_t vt [13];
  mips_instr_encoder_if #(.AW(AW)) bus ();
  mips_instr_encoder #(.DEPTH(4), .AW(AW), .BASE_ADDR('0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .restart(restart),
    .bus(bus),
    .err(err),
    .err_count(err_count),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.in_op = v.op;
    bus.in_funct = v.funct;
    bus.in_rs = v.rs;
    bus.in_rt = v.rt;
    bus.in_rd = v.rd;
    bus.in_shamt = v.sh;
    bus.in_imm = v.imm;
    bus.in_target = v.tgt;
  endtask
  task automatic send(input vec_t v, input string tag);
    int n, fw, fe, ne;
    logic [31:0] d;
    logic [AW-1:0] a;
    drive(v);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept"}, 32'(n < 20), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    fw = 0; fe = 0; ne = 0; d = '0; a = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (bus.wr_valid && fw == 0) begin
        fw = k;
        d = bus.wr_data;
        a = bus.wr_addr;
      end
      if (err) begin
        ne++;
        if (fe == 0) fe = k;
      end
    end
    if (v.bad) begin
      exp_err++;
      chk({tag, "_err_lat"}, fe, 1);
      chk({tag, "_err_width"}, ne, 1);
      chk({tag, "_no_write"}, fw, 0);
      chk({tag, "_err_count"}, err_count, exp_err);
    end else begin
      chk({tag, "_lat"}, fw, 2);
      chk({tag, "_data"}, d, v.exp);
      chk({tag, "_addr"}, a, exp_addr);
      chk({tag, "_no_err"}, ne, 0);
      exp_addr++;
    end
  endtask
  // offers n ADDIU r1,r0,j requests with wr_ready low for a fixed window
  task automatic push_n(input int n, output int acc, output bit unstable);
    logic ok;
    bit seen;
    logic [31:0] d0;
    logic [AW-1:0] a0;
    acc = 0; unstable = 0; seen = 0; d0 = '0; a0 = '0;
    for (int c = 0; c < 16; c++) begin
      if (acc < n) begin
        drive('{6'h09, 6'h00, 5'd0, 5'd1, 5'd0, 5'd0, 16'(acc), 26'd0, 1'b0, 32'd0});
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
      ok = bus.in_ready & bus.in_valid;
      @(posedge clk); #1;
      if (ok) acc++;
      if (bus.wr_valid) begin
        if (seen && (bus.wr_data !== d0 || bus.wr_addr !== a0)) unstable = 1;
        seen = 1;
        d0 = bus.wr_data;
        a0 = bus.wr_addr;
      end
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int acc;
    bit unstable;
    vt[0]  = '{6'h09, 6'h00, 5'd1,  5'd2,  5'd3, 5'd4, 16'hFFFC, 26'h0,   1'b0, 32'h2422FFFC};
    vt[1]  = '{6'h02, 6'h00, 5'd5,  5'd0,  5'd0, 5'd0, 16'h0,    26'h100, 1'b0, 32'h08000100};
    vt[2]  = '{6'h00, 6'h21, 5'd3,  5'd4,  5'd5, 5'd7, 16'h0,    26'h0,   1'b0, 32'h00642821};
    vt[3]  = '{6'h00, 6'h09, 5'd31, 5'd0,  5'd0, 5'd0, 16'h0,    26'h0,   1'b0, 32'h03E0F809};
    vt[4]  = '{6'h01, 6'h01, 5'd2,  5'd7,  5'd0, 5'd0, 16'h0004, 26'h0,   1'b0, 32'h04410004};
    vt[5]  = '{6'h0F, 6'h00, 5'd9,  5'd8,  5'd0, 5'd0, 16'h1234, 26'h0,   1'b0, 32'h3C081234};
    vt[6]  = '{6'h3F, 6'h00, 5'd1,  5'd2,  5'd3, 5'd4, 16'h5,    26'h6,   1'b1, 32'h0};
    vt[7]  = '{6'h00, 6'h00, 5'd5,  5'd6,  5'd7, 5'd3, 16'h0,    26'h0,   1'b0, 32'h000638C0};
    vt[8]  = '{6'h00, 6'h08, 5'd4,  5'd5,  5'd6, 5'd2, 16'h0,    26'h0,   1'b0, 32'h00800008};
    vt[9]  = '{6'h06, 6'h00, 5'd3,  5'd9,  5'd0, 5'd0, 16'h0010, 26'h0,   1'b0, 32'h18600010};
    vt[10] = '{6'h00, 6'h01, 5'd1,  5'd1,  5'd1, 5'd1, 16'h0,    26'h0,   1'b1, 32'h0};
    vt[11] = '{6'h2B, 6'h00, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'h0,   1'b0, 32'hAFBF0008};
    vt[12] = '{6'h00, 6'h09, 5'd2,  5'd3,  5'd5, 5'd4, 16'h0,    26'h0,   1'b0, 32'h00402809};
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    drive(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_instr_count", instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 13; i++) send(vt[i], $sformatf("v%0d", i));
    chk("mix_instr_count", instr_count, 11);
    chk("mix_err_count", err_count, 2);
    chk("mix_wr_addr", bus.wr_addr, 11);
    bus.wr_ready = 1'b0;
    push_n(6, acc, unstable);
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_stable", 32'(unstable), 0);
    chk("bp_head_valid", bus.wr_valid, 1);
    bus.wr_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_w%0d_valid", j), bus.wr_valid, 1);
      chk($sformatf("bp_w%0d_data", j), bus.wr_data, 32'h24010000 + 32'(j));
      chk($sformatf("bp_w%0d_addr", j), bus.wr_addr, exp_addr + j);
      @(posedge clk); #1;
    end
    exp_addr += 5;
    chk("bp_drained", bus.wr_valid, 0);
    chk("bp_instr_count", instr_count, exp_addr);
    bus.wr_ready = 1'b0;
    push_n(3, acc, unstable);
    chk("rs_accepted", acc, 3);
    chk("rs_queued", bus.wr_valid, 1);
    restart = 1'b1;
    #1;
    chk("rs_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    restart = 1'b0;
    chk("rs_wr_valid", bus.wr_valid, 0);
    chk("rs_wr_addr", bus.wr_addr, 0);
    chk("rs_instr_count", instr_count, 0);
    chk("rs_err_count", err_count, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("rs_flushed", bus.wr_valid, 0);
    bus.wr_ready = 1'b1;
    exp_addr = 0;
    send(vt[0], "rs_first");
    bus.wr_ready = 1'b0;
    push_n(2, acc, unstable);
    chk("ar_queued", bus.wr_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_valid", bus.wr_valid, 0);
    chk("ar_wr_addr", bus.wr_addr, 0);
    chk("ar_instr_count", instr_count, 0);
    chk("ar_err_count", err_count, 0);
    chk("ar_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_in_ready_back", bus.in_ready, 1);
    bus.wr_ready = 1'b1;
    exp_addr = 0;
    exp_err = 0;
    send(vt[5], "ar_first");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
